// File: rtl/microphones_if.sv
// Microphone pin and sample-output bundle for the microphones I2S receiver.
// The master modport is the receiver's view; the slave modport is the pins/consumer side.
interface microphones_if #(
    parameter int unsigned NUM_MICS = 1,
    parameter int unsigned SAMPLE_W = 24
);
    logic [NUM_MICS-1:0]          mic_data;
    logic                         mic_sck;
    logic                         mic_ws;
    logic [NUM_MICS*SAMPLE_W-1:0] sample_out;
    logic                         sample_channel;
    logic                         sample_valid;

    modport master (
        input  mic_data,
        output mic_sck,
        output mic_ws,
        output sample_out,
        output sample_channel,
        output sample_valid
    );

    modport slave (
        output mic_data,
        input  mic_sck,
        input  mic_ws,
        input  sample_out,
        input  sample_channel,
        input  sample_valid
    );
endinterface

// File: rtl/microphones.sv
// I2S master receiver: generates SCK/WS and deserialises SAMPLE_W-bit MSB-first samples per mic.
// Define MIC_STEREO_EN to capture the right slot as well; by default only the left slot is reported.
module microphones #(
    parameter int unsigned NUM_MICS = 1,
    parameter int unsigned SCK_DIV  = 32,
    parameter int unsigned SAMPLE_W = 24
) (
    input  logic          clk_in,
    input  logic          rst_in,
    microphones_if.master bus
);
    localparam int unsigned DIV_W   = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned OUT_W   = NUM_MICS * SAMPLE_W;
    localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(SCK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FALL_AT = DIV_W'(SCK_DIV - 1);
    localparam logic [4:0]       LAST_K  = 5'(SAMPLE_W);

`ifdef MIC_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    logic [DIV_W-1:0]                   div_q,   div_d;
    logic                               sck_q,   sck_d;
    logic [5:0]                         bit_q,   bit_d;
    logic                               ws_q,    ws_d;
    logic [NUM_MICS-1:0][SAMPLE_W-1:0]  shift_q, shift_d;
    logic                               done_q,  done_d;
    logic [OUT_W-1:0]                   out_q,   out_d;
    logic                               chan_q,  chan_d;
    logic                               valid_q, valid_d;

    logic       rise_c;
    logic       fall_c;
    logic       capture_c;
    logic [4:0] k_c;

    // Next-state: divider, frame counter, capture shift and completion strobe
    always_comb begin
        div_d   = div_q;
        sck_d   = sck_q;
        bit_d   = bit_q;
        ws_d    = ws_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        out_d   = out_q;
        chan_d  = chan_q;
        valid_d = 1'b0;

        rise_c    = (div_q == RISE_AT);
        fall_c    = (div_q == FALL_AT);
        k_c       = bit_q[4:0];
        capture_c = rise_c && (k_c != 5'd0) && (k_c <= LAST_K) && (STEREO || !ws_q);

        div_d = fall_c ? '0 : div_q + 1'b1;

        if (rise_c) begin
            sck_d = 1'b1;
        end
        // WS follows bit_cnt[5] and therefore only changes with the SCK falling edge
        if (fall_c) begin
            sck_d = 1'b0;
            bit_d = bit_q + 6'd1;
            ws_d  = bit_d[5];
        end

        if (capture_c) begin
            for (int unsigned m = 0; m < NUM_MICS; m++) begin
                shift_d[m] = {shift_q[m][SAMPLE_W-2:0], bus.mic_data[m]};
            end
            done_d = (k_c == LAST_K);
        end

        if (done_q) begin
            out_d   = shift_q;
            chan_d  = STEREO ? ws_q : 1'b0;
            valid_d = 1'b1;
        end
    end

    // State register; reset discards any partial sample
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            bit_q   <= '0;
            ws_q    <= 1'b0;
            shift_q <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
            chan_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            sck_q   <= sck_d;
            bit_q   <= bit_d;
            ws_q    <= ws_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            out_q   <= out_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign bus.mic_sck        = sck_q;
    assign bus.mic_ws         = ws_q;
    assign bus.sample_out     = out_q;
    assign bus.sample_channel = chan_q;
    assign bus.sample_valid   = valid_q;

endmodule

// File: tb/tb_microphones.sv
// Bench for microphones: an I2S mic model shifts words out on SCK falling edges and a
// scoreboard compares every sample_valid against the words the model transmitted.
module tb_microphones;
    localparam int unsigned NM    = 2;
    localparam int unsigned SW    = 24;
    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 64 * DIV;

`ifdef MIC_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    microphones_if #(.NUM_MICS(NM), .SAMPLE_W(SW)) mic_bus ();

    microphones #(.NUM_MICS(NM), .SCK_DIV(DIV), .SAMPLE_W(SW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (mic_bus)
    );

    typedef struct packed {
        logic [NM-1:0][SW-1:0] tx_l;
        logic [NM-1:0][SW-1:0] tx_r;
        logic [NM-1:0][SW-1:0] exp_l;
        logic [NM-1:0][SW-1:0] exp_r;
        logic                  pad;
    } frame_t;

    typedef struct packed {
        logic             ch;
        logic [NM*SW-1:0] val;
    } exp_t;

    frame_t tx_q[$];
    exp_t   exp_q[$];
    frame_t cur;
    frame_t vec[5];

    int       n_checks = 0;
    int       n_fail   = 0;
    int       tick_no  = 0;
    logic [5:0] cnt      = '0;
    logic     prev_sck   = 1'b0;
    logic     prev_valid = 1'b0;
    logic     loaded     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_frame();
        exp_t e;
        if (tx_q.size() > 0) cur = tx_q.pop_front();
        else                 cur = '0;
        e.ch  = 1'b0;
        e.val = cur.exp_l;
        exp_q.push_back(e);
        if (STEREO) begin
            e.ch  = 1'b1;
            e.val = cur.exp_r;
            exp_q.push_back(e);
        end
        loaded = 1'b1;
    endtask

    // Mic model: slot position from its own count of SCK falling edges
    task automatic drive_bits();
        int ki;
        ki = int'(cnt[4:0]);
        for (int m = 0; m < int'(NM); m++) begin
            if (ki >= 1 && ki <= int'(SW))
                mic_bus.mic_data[m] = cnt[5] ? cur.tx_r[m][int'(SW) - ki] : cur.tx_l[m][int'(SW) - ki];
            else
                mic_bus.mic_data[m] = cur.pad;
        end
    endtask

    task automatic step();
        exp_t e;
        logic fell;
        if (!rst_in) begin
            cnt        = '0;
            prev_sck   = 1'b0;
            prev_valid = 1'b0;
            loaded     = 1'b0;
            exp_q.delete();
            mic_bus.mic_data = '0;
            return;
        end
        if (mic_bus.sample_valid) begin
            check("valid_width", 64'(prev_valid), 64'd0);
            check("exp_available", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sample_channel", 64'(mic_bus.sample_channel), 64'(e.ch));
                check("sample_out", 64'(mic_bus.sample_out), 64'(e.val));
            end
        end
        prev_valid = mic_bus.sample_valid;
        fell       = prev_sck && !mic_bus.mic_sck;
        prev_sck   = mic_bus.mic_sck;
        if (fell) begin
            cnt = cnt + 6'd1;
            check("ws_align", 64'(mic_bus.mic_ws), 64'(cnt[5]));
        end
        if (!loaded || (fell && cnt == 6'd0)) load_frame();
        drive_bits();
    endtask

    task automatic tick();
        @(negedge clk_in);
        tick_no++;
        step();
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (tx_q.size() == 0 && exp_q.size() == 0) break;
            tick();
        end
        check(name, 64'(i < budget), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sck"},     64'(mic_bus.mic_sck), 64'd0);
        check({tag, "_ws"},      64'(mic_bus.mic_ws), 64'd0);
        check({tag, "_out"},     64'(mic_bus.sample_out), 64'd0);
        check({tag, "_channel"}, 64'(mic_bus.sample_channel), 64'd0);
        check({tag, "_valid"},   64'(mic_bus.sample_valid), 64'd0);
    endtask

    initial begin
        frame_t f;
        int t0, t, r1, r2, f1, wr, v, i;
        logic ps;
        real pi;
        pi = 3.14159265358979;

        vec[0] = '{tx_l: {24'h000000, 24'h7FFFFF}, tx_r: {24'h000000, 24'h000000},
                   exp_l: {24'h000000, 24'h7FFFFF}, exp_r: {24'h000000, 24'h000000}, pad: 1'b0};
        vec[1] = '{tx_l: {24'h7FFFFF, 24'h800001}, tx_r: {24'h000000, 24'h000000},
                   exp_l: {24'h7FFFFF, 24'h800001}, exp_r: {24'h000000, 24'h000000}, pad: 1'b1};
        vec[2] = '{tx_l: {24'hFEDCBA, 24'h123456}, tx_r: {24'h654321, 24'hABCDEF},
                   exp_l: {24'hFEDCBA, 24'h123456}, exp_r: {24'h654321, 24'hABCDEF}, pad: 1'b0};
        vec[3] = '{tx_l: {24'h000001, 24'hFFFFFF}, tx_r: {24'h7FFFFF, 24'h800000},
                   exp_l: {24'h000001, 24'hFFFFFF}, exp_r: {24'h7FFFFF, 24'h800000}, pad: 1'b1};
        vec[4] = '{tx_l: {24'hAAAAAA, 24'h555555}, tx_r: {24'h555555, 24'hAAAAAA},
                   exp_l: {24'hAAAAAA, 24'h555555}, exp_r: {24'h555555, 24'hAAAAAA}, pad: 1'b0};

        mic_bus.mic_data = '0;
        rst_in = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_in = 1'b1;
        t0 = tick_no;

        // SCK period/duty and first WS rise relative to reset release
        r1 = -1; r2 = -1; f1 = -1; wr = -1;
        ps = mic_bus.mic_sck;
        for (int n = 0; n < int'(40 * DIV) && wr < 0; n++) begin
            tick();
            t = tick_no - t0;
            if (!ps && mic_bus.mic_sck) begin
                if (r1 < 0) r1 = t;
                else if (r2 < 0) r2 = t;
            end
            if (ps && !mic_bus.mic_sck && f1 < 0) f1 = t;
            ps = mic_bus.mic_sck;
            if (mic_bus.mic_ws && wr < 0) wr = t;
        end
        check("first_sck_rise", 64'(r1), 64'(DIV / 2));
        check("sck_period", 64'(r2 - r1), 64'(DIV));
        check("sck_high", 64'(f1 - r1), 64'(DIV / 2));
        check("first_ws_rise", 64'(wr), 64'(32 * DIV));
        drain("drain_idle", 3 * int'(FRAME));

        for (int n = 0; n < 5; n++) begin
            tx_q.push_back(vec[n]);
            drain("drain_vec", 3 * int'(FRAME));
        end

        // Two-tone stream, negated on the second mic
        for (int n = 0; n < 40; n++) begin
            v = $rtoi(1048575.0 * $sin(2.0 * pi * n / 37.0) + 65535.0 * $sin(2.0 * pi * n / 5.3));
            f.tx_l[0] = SW'(v);
            f.tx_l[1] = SW'(-v);
            f.tx_r[0] = SW'(v >>> 1);
            f.tx_r[1] = SW'(-(v >>> 2));
            f.exp_l   = f.tx_l;
            f.exp_r   = f.tx_r;
            f.pad     = n[0];
            tx_q.push_back(f);
        end
        drain("drain_sine", 45 * int'(FRAME));

        // Truncated slot: reset 10 bits into the left slot
        tx_q.push_back(vec[2]);
        tx_q.push_back(vec[4]);
        for (i = 0; i < 4 * int'(FRAME); i++) begin
            if (tx_q.size() == 0 && loaded && cnt == 6'd10) break;
            tick();
        end
        check("reach_bit10", 64'(i < 4 * int'(FRAME)), 64'd1);
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) tick();
        tx_q.push_back(vec[3]);
        rst_in = 1'b1;
        drain("drain_after_reset", 3 * int'(FRAME));
        repeat (int'(FRAME)) tick();
        drain("drain_final", 2 * int'(FRAME));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
